// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    // Serializer states
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    // Store addresses decoded on the core's data bus (full 32-bit compare)
    localparam logic [31:0] TX_ADDR     = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;

    // Status word layout: {27'b0, overflow, busy, level[2:0]}
    localparam int unsigned STAT_LEVEL_LSB = 0;
    localparam int unsigned STAT_LEVEL_W   = 3;
    localparam int unsigned STAT_BUSY_BIT  = 3;
    localparam int unsigned STAT_OVF_BIT   = 4;

    // Bit in a STATUS_ADDR store that requests an overflow clear
    localparam int unsigned CTRL_CLR_OVF_BIT = 0;

    // Assemble the readback status word
    function automatic logic [31:0] pack_status(input logic [STAT_LEVEL_W-1:0] level,
                                                input logic                    busy,
                                                input logic                    ovf);
        logic [31:0] s;
        s = '0;
        s[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level;
        s[STAT_BUSY_BIT]                  = busy;
        s[STAT_OVF_BIT]                   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    // A pop on the same edge frees the slot, so a full FIFO still accepts that push
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL) && !pop;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter fed by core stores, with a byte FIFO and status word.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] StatusData
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    // Bus decode
    logic push_req;
    logic clr_req;
    logic drop;

    // FIFO interface
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic [AW:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;

    // Serializer state
    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        sh_q, sh_d;
    logic              tx_q, tx_d;
    logic              baud_end;

    // Sticky overflow
    logic ovf_q, ovf_d;

    // Only the low byte and the clear bit of a store carry meaning here
    logic unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    assign push_req = MemWrite && (DataAdr == TX_ADDR);
    assign clr_req  = MemWrite && (DataAdr == STATUS_ADDR) && WriteData[CTRL_CLR_OVF_BIT];
    assign drop     = push_req && fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (WriteData[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    // Serializer next-state: tx_d is the line level for the cycle after this edge
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_dout;
                    baud_d   = '0;
                    state_d  = StStart;
                    tx_d     = 1'b0;
                end
            end

            StStart: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                    tx_d      = sh_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                    tx_d   = 1'b0;
                end
            end

            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = sh_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_dout;
                        state_d  = StStart;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                    tx_d   = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Overflow next-state: a drop on the same edge as a clear wins
    always_comb begin
        ovf_d = ovf_q;
        if (clr_req) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Serializer and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            sh_q      <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    // Outputs derived from registers only
    always_comb begin
        tx         = tx_q;
        overflow   = ovf_q;
        busy       = (state_q != StIdle) || (fifo_count != '0);
        StatusData = pack_status(STAT_LEVEL_W'(fifo_count), busy, ovf_q);
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench: stores push expected bytes, a line monitor decodes frames and compares.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    localparam logic [31:0] A_TX  = 32'h1000_0000;
    localparam logic [31:0] A_ST  = 32'h1000_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [31:0] StatusData;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q [$];

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .StatusData (StatusData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] stat(input logic [2:0] lvl, input logic b, input logic o);
        return {27'b0, o, b, lvl};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one store; it is sampled at the following rising edge
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
    endtask

    // Wait (bounded) for busy to fall; check elapsed edges since t0 and that all frames arrived
    task automatic wait_idle(input int t0, input int exp_len, input string name);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, cyc - t0, exp_len);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_tx"}, tx, 1);
    endtask

    // Line monitor: decode each frame at bit centres and compare against the scoreboard
    initial begin : monitor
        bit         active;
        int         t;
        logic [9:0] bits;
        logic [7:0] exp_b;
        active = 1'b0;
        t      = 0;
        bits   = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                active = 1'b0;
                continue;
            end
            if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    t      = 0;
                    bits   = '0;
                end
            end else begin
                t++;
            end
            if (active) begin
                if ((t % CPB) == (CPB / 2)) bits[t / CPB] = tx;
                if (t == 10 * CPB - 1) begin
                    active = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame: unexpected frame bits=%b, expected no frame", bits);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("frame", {22'b0, bits}, {22'b0, 1'b1, exp_b, 1'b0});
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int t0;

        // Reset and idle
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_status", StatusData, 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx", tx, 1);
            check("idle_busy", busy, 0);
            check("idle_status", StatusData, 0);
        end

        // Single byte 0xA5
        exp_q.push_back(8'hA5);
        store(A_TX, 32'h0000_00A5);
        idle_bus();
        t0 = cyc;
        check("sb_tx_pre_pop", tx, 1);
        check("sb_status_k", StatusData, stat(3'd1, 1'b1, 1'b0));
        @(negedge clk);
        check("sb_tx_start", tx, 0);
        check("sb_status_k1", StatusData, stat(3'd0, 1'b1, 1'b0));
        wait_idle(t0, 41, "sb_len");

        // Back-to-back 0x41, 0x42, 0x43
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        store(A_TX, 32'h41);
        store(A_TX, 32'h42);
        t0 = cyc;
        store(A_TX, 32'h43);
        check("b2b_level_1", StatusData, stat(3'd1, 1'b1, 1'b0));
        idle_bus();
        check("b2b_level_2", StatusData, stat(3'd2, 1'b1, 1'b0));
        @(negedge clk);
        check("b2b_level_3", StatusData, stat(3'd2, 1'b1, 1'b0));
        wait_idle(t0, 121, "b2b_len");

        // Overflow: six stores, the sixth is dropped
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
        store(A_TX, 32'h10);
        store(A_TX, 32'h11);
        t0 = cyc;
        for (int i = 2; i < 6; i++) store(A_TX, 32'h10 + 32'(i));
        idle_bus();
        check("ovf_flag", overflow, 1);
        check("ovf_status", StatusData, stat(3'd4, 1'b1, 1'b1));
        store(A_ST, 32'h2);
        idle_bus();
        check("ovf_no_clear_bit0_0", overflow, 1);
        store(A_ST, 32'h1);
        idle_bus();
        check("ovf_cleared", overflow, 0);
        check("ovf_cleared_status", StatusData, stat(3'd4, 1'b1, 1'b0));
        wait_idle(t0, 201, "ovf_len");

        // Ignored addresses
        store(32'h1000_0008, 32'h55);
        store(32'h0000_0000, 32'h55);
        idle_bus();
        check("ign_status_now", StatusData, 0);
        repeat (50) @(negedge clk);
        check("ign_status_later", StatusData, 0);
        check("ign_tx", tx, 1);

        // Clear immediately followed by a dropped push: overflow ends set
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h60 + 8'(i));
        for (int i = 0; i < 5; i++) store(A_TX, 32'h60 + 32'(i));
        store(A_ST, 32'h1);
        store(A_TX, 32'h65);
        idle_bus();
        check("race_ovf", overflow, 1);
        check("race_status", StatusData, stat(3'd4, 1'b1, 1'b1));

        // Asynchronous reset in the middle of the first frame (a zero data bit)
        repeat (10) @(negedge clk);
        check("mid_tx_low", tx, 0);
        #2 reset = 1'b0;
        #1;
        check("async_tx", tx, 1);
        check("async_status", StatusData, 0);
        check("async_ovf", overflow, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("post_rst_tx", tx, 1);
        check("post_rst_status", StatusData, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
